// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads instruction memory combinationally and
// queues {pc, instr} pairs for decode. Handles redirects, halt and misaligned targets.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [1:0]  state_dbg
);

    // Handshake: a head entry transfers when out_valid && out_ready in a cycle with
    // no redirect; a redirect voids out_ready and squashes every buffered entry.

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;
    logic [31:0]    fcount_q, fcount_d;
    logic [31:0]    buf_instr_q [BUF_DEPTH];
    logic [31:0]    buf_instr_d [BUF_DEPTH];
    logic [31:0]    buf_pc_q    [BUF_DEPTH];
    logic [31:0]    buf_pc_d    [BUF_DEPTH];

    logic           misalign;
    logic           pop;
    logic           push;

    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign out_valid = (count_q != '0) && (state_q != ST_ERR);
    assign pop       = out_valid && out_ready && !redirect_valid;
    // At full, a push is still allowed when the head leaves in the same cycle.
    assign push      = (state_q == ST_RUN) && !halt && !redirect_valid &&
                       ((count_q < DEPTH_C) || pop);

    assign imem_addr    = pc_q;
    assign out_instr    = out_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign out_pc       = out_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
    assign misalign_err = err_q;
    assign fetch_count  = fcount_q;
    assign state_dbg    = state_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        fcount_d    = fcount_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (misalign) begin
            // Fetch PC is left alone so imem_addr freezes at the last good address.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b1;
            state_d  = ST_ERR;
        end else if (redirect_valid && (state_q != ST_ERR)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pc_d     = redirect_pc;
        end else begin
            case (state_q)
                ST_RUN:  if (halt)  state_d = ST_HALT;
                ST_HALT: if (!halt) state_d = ST_RUN;
                default: state_d = state_q;
            endcase

            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_instr;
                buf_pc_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                pc_d                  = pc_q + 32'd4;
                fcount_d              = fcount_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            fcount_q <= 32'h0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= 32'h0;
                buf_pc_q[i]    <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            fcount_q    <= fcount_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the RV32I core. Owns the fetch program counter, drives the word-addressed instruction memory (combinational read, `addr[17:2]` index), and buffers fetched words with their PCs in a small FIFO. The FIFO presents them to decode over a valid/ready handshake. Branch/jump redirects, halt and misaligned-target detection are handled here, so decode never sees stale or wrong-path instructions after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be 0.
- `BUF_DEPTH`, default 2: fetch buffer entries; power of two, 2..8.

- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_addr`  out  32: fetch address to instruction memory; equals fetch PC register.
- `imem_instr`  in  32: instruction word; valid in the same cycle as `imem_addr`.
- `out_valid`  out  1: buffer head holds an instruction.
- `out_ready`  in  1: decode accepts head this cycle.
- `out_instr`  out  32: head instruction; 0 when `out_valid`=0.
- `out_pc`  out  32: head PC; 0 when `out_valid`=0.
- `redirect_valid`  in  1: taken branch/jump/jalr this cycle.
- `redirect_pc`  in  32: redirect target.
- `halt`  in  1: suspend new fetches; buffer still drains.
- `misalign_err`  out  1: sticky misaligned-redirect flag.
- `fetch_count`  out  32: number of words pushed since reset, wraps modulo 2^32.

## Operation
- State machine: RUN, HALT, ERR. Reset enters RUN.
- RUN goes to HALT when `halt`=1; this is combinationally gated, so no fetch occurs in that cycle. HALT goes to RUN when `halt`=0.
- Any state goes to ERR on `redirect_valid` with `redirect_pc[1:0]`≠0. ERR exits only on `rst`.
- pop = `out_valid` & `out_ready` & !`redirect_valid`.
- push = (state==RUN) & !`halt` & !`redirect_valid` & (count<BUF_DEPTH | pop).
- On push:
  - write {fetch PC, `imem_instr`} at the tail;
  - fetch PC += 4, with 32-bit wrap (0xFFFF_FFFC → 0);
  - `fetch_count` += 1.
- Push and pop in the same cycle: count unchanged. A push is legal at full when a pop also occurs.
- Aligned redirect, in RUN or HALT:
  - flush the buffer (count←0, pointers reset);
  - fetch PC ← `redirect_pc`;
  - no push or pop that cycle;
  - the state is unchanged.
- Redirect has priority over the handshake. An `out_ready` in the redirect cycle is void, and decode must treat the head as squashed.
- Misaligned redirect:
  - flush the buffer;
  - fetch PC is unchanged;
  - `misalign_err`←1;
  - state←ERR.
- In ERR: no push, `out_valid`=0, and `imem_addr` holds.
- Reset values:
  - fetch PC = RESET_PC, so `imem_addr`=RESET_PC;
  - count=0, `out_valid`=0, `out_instr`=0, `out_pc`=0;
  - `misalign_err`=0, `fetch_count`=0, state=RUN.
- `rst` mid-operation discards buffer contents and any concurrent redirect, halt or handshake.

## Timing
- `imem_addr` is registered (fetch PC). `out_*` come from buffer registers, with no combinational path from `imem_instr` to `out_instr`.
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N is visible at `out_valid` after edge N.
- First instruction after reset deassert: `out_valid`=1 one cycle after the first RUN cycle.
- Redirect at cycle N:
  - cycle N+1: `out_valid`=0, `imem_addr`=target;
  - cycle N+2: `out_pc`=target.
  - Redirect penalty is 2 cycles.
- Steady-state throughput is 1 instruction/cycle with `out_ready` held high.
- `out_valid`, once high, stays high with stable data until a pop, redirect or reset.

## Test plan
- Memory model word i = 0x100+i, RESET_PC=0, `out_ready`=1 → `out_pc` 0,4,8,… with `out_instr` 0x100,0x101,0x102 on consecutive cycles; `fetch_count` increments every cycle.
- Hold `out_ready`=0 for 5 cycles after reset → count saturates at 2, `imem_addr` holds 0x8, `fetch_count`=2. Release → `out_pc` 0,4,8 in order, no drop or duplicate.
- Buffer full, `redirect_valid`=1 with `redirect_pc`=0x40 and `out_ready`=1 in the same cycle → next cycle `out_valid`=0 and `imem_addr`=0x40; following cycle `out_pc`=0x40 and `out_instr`=0x110; the squashed head is never re-presented.
- `halt`=1 for 3 cycles mid-stream → no pushes, buffer drains to empty, `imem_addr` frozen. Redirect to 0x80 during halt → on resume first `out_pc`=0x80.
- `redirect_pc`=0x42 → `misalign_err`=1, `out_valid`=0 indefinitely, `imem_addr` unchanged. Only `rst`=1 restores fetching from RESET_PC with `misalign_err`=0.
- RESET_PC=0xFFFF_FFF8 → `out_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
